cond_unit_pipe: RTL

Pipelined, parametrised condition unit for the pipelined ARM-like core. It holds the Decode→Execute register for the predication controls and owns the NZCV flag register. It evaluates each instruction's 4-bit condition in Execute and gates PCSrc, RegWrite, MemWrite and FlagWrite. It adds IT-block predication: an IT instruction sets a condition, a length and a then/else mask that override the condition field of up to IT_DEPTH following instructions.

---
 rtl/cond_unit_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cond_unit_pipe.sv
// Predication unit for the pipelined core: D->E register for condition controls,
// NZCV flag register, condition evaluation and IT-block override of up to IT_DEPTH instructions.
module cond_unit_pipe #(
    parameter  int IT_DEPTH = 4,
    localparam int CW       = $clog2(IT_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic                ValidD,
    input  logic [3:0]          CondD,
    input  logic [1:0]          FlagWD,
    input  logic                PCSD,
    input  logic                RegWD,
    input  logic                MemWD,
    input  logic                ITStartD,
    input  logic [3:0]          ITCondD,
    input  logic [CW-1:0]       ITLenD,
    input  logic [IT_DEPTH-1:0] ITMaskD,
    input  logic [3:0]          ALUFlagsE,
    output logic                CondExE,
    output logic                PCSrcE,
    output logic                RegWriteE,
    output logic                MemWriteE,
    output logic [3:0]          FlagsQ,
    output logic                ITActive,
    output logic [CW-1:0]       ITRemain
);
    typedef enum logic {IDLE, ACTIVE} it_state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(IT_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic                valid_e, pcs_e, regw_e, memw_e, it_start_e;
    logic [3:0]          cond_e, it_cond_e;
    logic [1:0]          flagw_e;
    logic [CW-1:0]       it_len_e;
    logic [IT_DEPTH-1:0] it_mask_e;

    it_state_t           state, state_n;
    logic [3:0]          it_cond, it_cond_n;
    logic [CW-1:0]       it_len, it_len_n, it_remain, it_remain_n;
    logic [IT_DEPTH-1:0] it_mask, it_mask_n, mask_sh;
    logic [CW-1:0]       idx;
    logic [3:0]          eff_cond;
    logic                advance;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = cf;
            4'b0011: cond_pass = ~cf;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = cf & ~z;
            4'b1001: cond_pass = ~cf | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_e    <= 1'b0;
            cond_e     <= '0;
            flagw_e    <= '0;
            pcs_e      <= 1'b0;
            regw_e     <= 1'b0;
            memw_e     <= 1'b0;
            it_start_e <= 1'b0;
            it_cond_e  <= '0;
            it_len_e   <= '0;
            it_mask_e  <= '0;
        end else if (!StallE) begin
            valid_e    <= ValidD & ~FlushE;
            cond_e     <= CondD;
            flagw_e    <= FlagWD;
            pcs_e      <= PCSD;
            regw_e     <= RegWD;
            memw_e     <= MemWD;
            it_start_e <= ITStartD;
            it_cond_e  <= ITCondD;
            it_len_e   <= ITLenD;
            it_mask_e  <= ITMaskD;
        end
    end

    // Position within the IT block selects the then/else bit of the mask.
    assign idx      = it_len - it_remain;
    assign mask_sh  = it_mask >> idx;
    assign eff_cond = (state == ACTIVE) ? (mask_sh[0] ? it_cond : it_cond ^ 4'b0001) : cond_e;

    assign CondExE   = valid_e & cond_pass(eff_cond, FlagsQ);
    assign PCSrcE    = pcs_e & CondExE;
    assign RegWriteE = regw_e & CondExE;
    assign MemWriteE = memw_e & CondExE;
    assign ITActive  = (state == ACTIVE);
    assign ITRemain  = it_remain;
    assign advance   = valid_e & ~StallE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FlagsQ <= '0;
        end else begin
            if (flagw_e[1] & CondExE & ~StallE) FlagsQ[3:2] <= ALUFlagsE[3:2];
            if (flagw_e[0] & CondExE & ~StallE) FlagsQ[1:0] <= ALUFlagsE[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            it_cond   <= '0;
            it_len    <= '0;
            it_mask   <= '0;
            it_remain <= '0;
        end else begin
            state     <= state_n;
            it_cond   <= it_cond_n;
            it_len    <= it_len_n;
            it_mask   <= it_mask_n;
            it_remain <= it_remain_n;
        end
    end

    always_comb begin
        state_n     = state;
        it_cond_n   = it_cond;
        it_len_n    = it_len;
        it_mask_n   = it_mask;
        it_remain_n = it_remain;
        case (state)
            IDLE: begin
                if (advance && it_start_e && CondExE && it_len_e != '0 && it_len_e <= DEPTH_C) begin
                    state_n     = ACTIVE;
                    it_cond_n   = it_cond_e;
                    it_len_n    = it_len_e;
                    it_mask_n   = it_mask_e;
                    it_remain_n = it_len_e;
                end
            end
            ACTIVE: begin
                // A taken branch leaves the block early; pass or fail, every real instruction consumes a slot.
                if (advance) begin
                    if (PCSrcE || it_remain == ONE_C) begin
                        state_n     = IDLE;
                        it_remain_n = '0;
                    end else begin
                        it_remain_n = it_remain - ONE_C;
                    end
                end
            end
            default: begin
                state_n     = IDLE;
                it_remain_n = '0;
            end
        endcase
    end
endmodule
